// File: rtl/w5300_socket_array_conf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : w5300_socket_array_conf_pkg
// Description : W5300 socket register map, command/status codes and mode enum.
// Revision    : 1.0 - initial release
// ============================================================================
package w5300_socket_array_conf_pkg;

    typedef enum logic [1:0] {
        TCP_SERVER = 2'd0,
        TCP_CLIENT = 2'd1,
        UDP        = 2'd2,
        SKIP       = 2'd3
    } sock_mode_t;

    localparam logic       c_RD       = 1'b1;
    localparam logic       c_WR       = 1'b0;
    localparam logic [9:0] c_IDLE_REG = 10'h3FE;

    // Socket 0 register addresses; socket n is 0x40 higher per index
    localparam logic [9:0] c_SN_MR             = 10'h200;
    localparam logic [9:0] c_SN_CR             = 10'h202;
    localparam logic [9:0] c_SN_IMR            = 10'h204;
    localparam logic [9:0] c_SN_SSR            = 10'h208;
    localparam logic [9:0] c_SN_PORTR          = 10'h20A;
    localparam logic [9:0] c_SN_DPORTR         = 10'h212;
    localparam logic [9:0] c_SN_DIPR0          = 10'h214;
    localparam logic [9:0] c_SN_DIPR2          = 10'h216;
    localparam logic [9:0] c_SN_KPALVTR_PROTOR = 10'h21A;

    localparam logic [7:0] c_SN_MR_TCP   = 8'h01;
    localparam logic [7:0] c_SN_MR_P_UDP = 8'h02;
    localparam logic [7:0] c_SN_MR_ND    = 8'h20;

    localparam logic [7:0] c_SN_CR_OPEN    = 8'h01;
    localparam logic [7:0] c_SN_CR_LISTEN  = 8'h02;
    localparam logic [7:0] c_SN_CR_CONNECT = 8'h04;
    localparam logic [7:0] c_SN_CR_CLOSE   = 8'h10;

    localparam logic [7:0] c_SN_IMR_ALL = 8'h1F;

    localparam logic [7:0] c_SN_SSR_SOCK_INIT        = 8'h13;
    localparam logic [7:0] c_SN_SSR_SOCK_LISTEN      = 8'h14;
    localparam logic [7:0] c_SN_SSR_SOCK_ESTABLISHED = 8'h17;
    localparam logic [7:0] c_SN_SSR_SOCK_UDP         = 8'h22;

    function automatic logic [9:0] get_socket_n_reg(input logic [9:0] base,
                                                    input logic [2:0] sock_idx);
        return base + {1'b0, sock_idx, 6'b000000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/w5300_socket_array_conf_poll_timer.sv
`default_nettype none
// ============================================================================
// Module      : w5300_poll_timer
// Description : Saturating poll-cycle counter with clear, enable and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module w5300_poll_timer #(
    parameter int TIMEOUT = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic overflow
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_count;

    // Saturates at the limit so a long stall can never wrap back below it
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign overflow = (r_count >= c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/w5300_socket_array_conf.sv
`default_nettype none
// ============================================================================
// Module      : w5300_socket_array_conf
// Description : Sequentially opens N_SOCK W5300 sockets with per-socket retry.
// Revision    : 1.0 - initial release
// ============================================================================
module w5300_socket_array_conf
    import w5300_socket_array_conf_pkg::*;
#(
    parameter int          N_SOCK       = 2,
    parameter logic [15:0] MODES        = 16'h0000,
    parameter int          BASE_PORT    = 7000,
    parameter logic [31:0] DEST_IP      = 32'hC0A80164,
    parameter int          DEST_PORT    = 8000,
    parameter int          POLL_TIMEOUT = 50,
    parameter int          MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              op_state,
    input  logic [15:0]       rd_data,
    output logic [10:0]       addr,
    output logic [15:0]       wr_data,
    output logic              done,
    output logic              error,
    output logic [N_SOCK-1:0] sock_ok
);

    localparam logic [3:0] c_ST_IDLE       = 4'd0;
    localparam logic [3:0] c_ST_PARAMS     = 4'd1;
    localparam logic [3:0] c_ST_OPEN       = 4'd2;
    localparam logic [3:0] c_ST_POLL_INIT  = 4'd3;
    localparam logic [3:0] c_ST_LISTEN     = 4'd4;
    localparam logic [3:0] c_ST_CONNECT    = 4'd5;
    localparam logic [3:0] c_ST_POLL_FINAL = 4'd6;
    localparam logic [3:0] c_ST_CLOSE      = 4'd7;
    localparam logic [3:0] c_ST_NEXT       = 4'd8;
    localparam logic [3:0] c_ST_DONE       = 4'd9;

    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);

    logic [3:0]           r_state;
    logic [3:0]           w_state_nxt;
    logic [2:0]           r_sock_idx;
    logic [2:0]           r_op_cnt;
    logic [c_RETRY_W-1:0] r_retry;
    logic                 r_error;
    logic [N_SOCK-1:0]    r_sock_ok;

    sock_mode_t        w_mode;
    logic              w_in_poll;
    logic              w_timer_clr;
    logic              w_timeout;
    logic              w_match;
    logic              w_params_last;
    logic              w_next_found;
    logic [2:0]        w_next_idx;
    logic [7:0]        w_target;
    logic [N_SOCK-1:0] w_sock_sel;
    logic [15:0]       w_mr_val;
    logic              w_rw;
    logic [9:0]        w_reg;

    assign w_mode        = sock_mode_t'(MODES[{r_sock_idx, 1'b0} +: 2]);
    assign w_in_poll     = (r_state == c_ST_POLL_INIT) || (r_state == c_ST_POLL_FINAL);
    assign w_timer_clr   = !w_in_poll;
    assign w_params_last = (w_mode == TCP_CLIENT) ? (r_op_cnt == 3'd6) : (r_op_cnt == 3'd3);
    assign w_mr_val      = (w_mode == UDP) ? {8'h00, c_SN_MR_P_UDP}
                                           : {8'h00, c_SN_MR_TCP | c_SN_MR_ND};

    always_comb begin
        w_target = c_SN_SSR_SOCK_INIT;
        if (r_state == c_ST_POLL_INIT) begin
            w_target = (w_mode == UDP) ? c_SN_SSR_SOCK_UDP : c_SN_SSR_SOCK_INIT;
        end else begin
            w_target = (w_mode == TCP_CLIENT) ? c_SN_SSR_SOCK_ESTABLISHED
                                              : c_SN_SSR_SOCK_LISTEN;
        end
    end

    assign w_match = op_state && w_in_poll && (rd_data == {8'h00, w_target});

    // Lowest-numbered non-skipped socket above the current one
    always_comb begin
        w_next_found = 1'b0;
        w_next_idx   = r_sock_idx;
        for (int i = N_SOCK - 1; i >= 0; i--) begin
            if ((i > int'(r_sock_idx)) && (sock_mode_t'(MODES[2*i +: 2]) != SKIP)) begin
                w_next_found = 1'b1;
                w_next_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        w_sock_sel = '0;
        for (int i = 0; i < N_SOCK; i++) begin
            w_sock_sel[i] = (3'(i) == r_sock_idx);
        end
    end

    w5300_poll_timer #(
        .TIMEOUT (POLL_TIMEOUT)
    ) u_poll_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_timer_clr),
        .enable   (w_in_poll),
        .overflow (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A status match outranks a simultaneous timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = (w_mode == SKIP) ? c_ST_NEXT : c_ST_PARAMS;
                end
            end
            c_ST_PARAMS: begin
                if (op_state && w_params_last) w_state_nxt = c_ST_OPEN;
            end
            c_ST_OPEN: begin
                if (op_state) w_state_nxt = c_ST_POLL_INIT;
            end
            c_ST_POLL_INIT: begin
                if (w_match) begin
                    if (w_mode == UDP)             w_state_nxt = c_ST_NEXT;
                    else if (w_mode == TCP_CLIENT) w_state_nxt = c_ST_CONNECT;
                    else                           w_state_nxt = c_ST_LISTEN;
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_CLOSE;
                end
            end
            c_ST_LISTEN, c_ST_CONNECT: begin
                if (op_state) w_state_nxt = c_ST_POLL_FINAL;
            end
            c_ST_POLL_FINAL: begin
                if (w_match)        w_state_nxt = c_ST_NEXT;
                else if (w_timeout) w_state_nxt = c_ST_CLOSE;
            end
            c_ST_CLOSE: begin
                if (op_state) begin
                    w_state_nxt = (r_retry < c_MAX_RETRY) ? c_ST_PARAMS : c_ST_NEXT;
                end
            end
            c_ST_NEXT: begin
                w_state_nxt = w_next_found ? c_ST_PARAMS : c_ST_DONE;
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_DONE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sock_idx <= '0;
            r_op_cnt   <= '0;
            r_retry    <= '0;
            r_error    <= 1'b0;
            r_sock_ok  <= '0;
        end else begin
            case (r_state)
                c_ST_PARAMS: begin
                    if (op_state) r_op_cnt <= w_params_last ? 3'd0 : r_op_cnt + 3'd1;
                end
                c_ST_POLL_INIT: begin
                    if (w_match && (w_mode == UDP)) r_sock_ok <= r_sock_ok | w_sock_sel;
                end
                c_ST_POLL_FINAL: begin
                    if (w_match) r_sock_ok <= r_sock_ok | w_sock_sel;
                end
                c_ST_CLOSE: begin
                    if (op_state) begin
                        if (r_retry < c_MAX_RETRY) begin
                            r_retry <= r_retry + c_RETRY_W'(1);
                        end else begin
                            r_error   <= 1'b1;
                            r_sock_ok <= r_sock_ok & ~w_sock_sel;
                        end
                    end
                end
                c_ST_NEXT: begin
                    r_retry <= '0;
                    if (w_next_found) r_sock_idx <= w_next_idx;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_rw    = c_RD;
        w_reg   = c_IDLE_REG;
        wr_data = '0;
        done    = 1'b0;
        case (r_state)
            c_ST_PARAMS: begin
                w_rw = c_WR;
                case (r_op_cnt)
                    3'd0: begin
                        w_reg   = get_socket_n_reg(c_SN_MR, r_sock_idx);
                        wr_data = w_mr_val;
                    end
                    3'd1: begin
                        w_reg   = get_socket_n_reg(c_SN_PORTR, r_sock_idx);
                        wr_data = 16'(BASE_PORT) + {13'd0, r_sock_idx};
                    end
                    3'd2: begin
                        w_reg   = get_socket_n_reg(c_SN_IMR, r_sock_idx);
                        wr_data = {8'h00, c_SN_IMR_ALL};
                    end
                    3'd3: begin
                        w_reg   = get_socket_n_reg(c_SN_KPALVTR_PROTOR, r_sock_idx);
                        wr_data = {8'd1, 8'd1};
                    end
                    3'd4: begin
                        w_reg   = get_socket_n_reg(c_SN_DIPR0, r_sock_idx);
                        wr_data = DEST_IP[31:16];
                    end
                    3'd5: begin
                        w_reg   = get_socket_n_reg(c_SN_DIPR2, r_sock_idx);
                        wr_data = DEST_IP[15:0];
                    end
                    default: begin
                        w_reg   = get_socket_n_reg(c_SN_DPORTR, r_sock_idx);
                        wr_data = 16'(DEST_PORT);
                    end
                endcase
            end
            c_ST_OPEN: begin
                w_rw    = c_WR;
                w_reg   = get_socket_n_reg(c_SN_CR, r_sock_idx);
                wr_data = {8'h00, c_SN_CR_OPEN};
            end
            c_ST_LISTEN: begin
                w_rw    = c_WR;
                w_reg   = get_socket_n_reg(c_SN_CR, r_sock_idx);
                wr_data = {8'h00, c_SN_CR_LISTEN};
            end
            c_ST_CONNECT: begin
                w_rw    = c_WR;
                w_reg   = get_socket_n_reg(c_SN_CR, r_sock_idx);
                wr_data = {8'h00, c_SN_CR_CONNECT};
            end
            c_ST_CLOSE: begin
                w_rw    = c_WR;
                w_reg   = get_socket_n_reg(c_SN_CR, r_sock_idx);
                wr_data = {8'h00, c_SN_CR_CLOSE};
            end
            c_ST_POLL_INIT, c_ST_POLL_FINAL: begin
                w_reg = get_socket_n_reg(c_SN_SSR, r_sock_idx);
            end
            c_ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        addr = {w_rw, w_reg};
    end

    assign error   = r_error;
    assign sock_ok = r_sock_ok;

endmodule
`default_nettype wire

// File: tb/tb_w5300_socket_array_conf.sv
`default_nettype none
// ============================================================================
// Module      : tb_w5300_socket_array_conf
// Description : Directed bench: server/client/UDP/skip sockets, retry, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w5300_socket_array_conf;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        op_state;
    logic [15:0] rd_data;
    logic [10:0] addr;
    logic [15:0] wr_data;
    logic        done;
    logic        error;
    logic [3:0]  sock_ok;

    logic        skip_op = 1'b0;
    logic [15:0] skip_rd = 16'h0000;
    logic [10:0] skip_addr;
    logic [15:0] skip_wr_data;
    logic        skip_done;
    logic        skip_error;
    logic [1:0]  skip_sock_ok;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Socket 0 server, 1 client, 2 UDP, 3 skipped
    w5300_socket_array_conf #(
        .N_SOCK       (4),
        .MODES        (16'h00E4),
        .BASE_PORT    (7000),
        .DEST_IP      (32'hC0A80164),
        .DEST_PORT    (8000),
        .POLL_TIMEOUT (50),
        .MAX_RETRY    (2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .op_state (op_state),
        .rd_data  (rd_data),
        .addr     (addr),
        .wr_data  (wr_data),
        .done     (done),
        .error    (error),
        .sock_ok  (sock_ok)
    );

    w5300_socket_array_conf #(
        .N_SOCK (2),
        .MODES  (16'h000F)
    ) u_all_skip (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .op_state (skip_op),
        .rd_data  (skip_rd),
        .addr     (skip_addr),
        .wr_data  (skip_wr_data),
        .done     (skip_done),
        .error    (skip_error),
        .sock_ok  (skip_sock_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input logic [9:0] reg_a, input logic [15:0] data);
        chk({tag, "_addr"}, 32'(addr), 32'({1'b0, reg_a}));
        chk({tag, "_data"}, 32'(wr_data), 32'(data));
        op_state = 1'b1;
        @(negedge clk);
        op_state = 1'b0;
    endtask

    task automatic expect_rd(input string tag, input logic [9:0] reg_a,
                             input logic [15:0] rdata, input int wait_cyc);
        chk({tag, "_addr"}, 32'(addr), 32'({1'b1, reg_a}));
        repeat (wait_cyc) @(negedge clk);
        op_state = 1'b1;
        rd_data  = rdata;
        @(negedge clk);
        op_state = 1'b0;
        rd_data  = 16'h0000;
    endtask

    task automatic expect_next(input string tag);
        chk(tag, 32'(addr), 32'h7FE);
        @(negedge clk);
    endtask

    task automatic sock_params(input logic [9:0] base, input logic [15:0] mr,
                               input logic [15:0] port, input bit client);
        expect_wr("mr", base, mr);
        expect_wr("portr", base + 10'h00A, port);
        expect_wr("imr", base + 10'h004, 16'h001F);
        expect_wr("kpalv_proto", base + 10'h01A, 16'h0101);
        if (client) begin
            expect_wr("dipr0", base + 10'h014, 16'hC0A8);
            expect_wr("dipr2", base + 10'h016, 16'h0164);
            expect_wr("dportr", base + 10'h012, 16'h1F40);
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        op_state = 1'b0;
        rd_data  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(addr), 32'h7FE);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_sock_ok", 32'(sock_ok), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_without_enable", 32'(addr), 32'h7FE);

        // Run 1: every socket answers promptly
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("skip_done_after_1", 32'(skip_done), 32'h0);
        @(negedge clk);
        chk("skip_done_after_2", 32'(skip_done), 32'h1);
        chk("skip_sock_ok", 32'(skip_sock_ok), 32'h0);
        chk("skip_error", 32'(skip_error), 32'h0);
        chk("skip_addr_idle", 32'(skip_addr), 32'h7FE);

        sock_params(10'h200, 16'h0021, 16'd7000, 1'b0);
        expect_wr("s0_open", 10'h202, 16'h0001);
        expect_rd("s0_ssr_nomatch", 10'h208, 16'h0000, 2);
        expect_rd("s0_ssr_init", 10'h208, 16'h0013, 0);
        expect_wr("s0_listen", 10'h202, 16'h0002);
        expect_rd("s0_ssr_listen", 10'h208, 16'h0014, 1);
        expect_next("s0_next");
        chk("s0_sock_ok", 32'(sock_ok), 32'h1);

        sock_params(10'h240, 16'h0021, 16'd7001, 1'b1);
        expect_wr("s1_open", 10'h242, 16'h0001);
        expect_rd("s1_ssr_init", 10'h248, 16'h0013, 0);
        expect_wr("s1_connect", 10'h242, 16'h0004);
        expect_rd("s1_ssr_estab", 10'h248, 16'h0017, 0);
        expect_next("s1_next");

        sock_params(10'h280, 16'h0002, 16'd7002, 1'b0);
        expect_wr("s2_open", 10'h282, 16'h0001);
        expect_rd("s2_ssr_udp", 10'h288, 16'h0022, 0);
        expect_next("s2_next_no_listen");

        chk("run1_done", 32'(done), 32'h1);
        chk("run1_sock_ok", 32'(sock_ok), 32'h7);
        chk("run1_error", 32'(error), 32'h0);
        chk("run1_done_addr", 32'(addr), 32'h7FE);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        chk("done_ignores_enable", 32'(done), 32'h1);
        chk("done_ignores_enable_addr", 32'(addr), 32'h7FE);

        // Run 2: socket 0 never reaches INIT and exhausts its retries
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_clears_done", 32'(done), 32'h0);
        chk("rst_clears_sock_ok", 32'(sock_ok), 32'h0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int a = 0; a < 3; a++) begin
            sock_params(10'h200, 16'h0021, 16'd7000, 1'b0);
            expect_wr("retry_open", 10'h202, 16'h0001);
            chk("retry_poll_addr", 32'(addr), 32'h608);
            repeat (50) @(negedge clk);
            chk("retry_poll_tick50", 32'(addr), 32'h608);
            @(negedge clk);
            expect_wr("retry_close", 10'h202, 16'h0010);
        end
        expect_next("retry_exhausted_next");
        chk("retry_error", 32'(error), 32'h1);
        chk("retry_sock_ok", 32'(sock_ok), 32'h0);

        sock_params(10'h240, 16'h0021, 16'd7001, 1'b1);
        expect_wr("s1b_open", 10'h242, 16'h0001);
        expect_rd("s1b_match_at_timeout", 10'h248, 16'h0013, 50);
        expect_wr("s1b_connect_not_close", 10'h242, 16'h0004);
        expect_rd("s1b_ssr_estab", 10'h248, 16'h0017, 0);
        expect_next("s1b_next");
        chk("run2_sock_ok", 32'(sock_ok), 32'h2);
        chk("run2_error_sticky", 32'(error), 32'h1);

        // Abort in the middle of socket 2's parameter writes
        expect_wr("s2b_mr", 10'h280, 16'h0002);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_addr", 32'(addr), 32'h7FE);
        chk("abort_wr_data", 32'(wr_data), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_error", 32'(error), 32'h0);
        chk("abort_sock_ok", 32'(sock_ok), 32'h0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        expect_wr("restart_s0_mr", 10'h200, 16'h0021);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
